// File: rtl/alu_pkg.sv
// Shared constants for the ALU integer execution slice: datapath width and op codes.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [4:0] OP_BEQ  = 5'd0;
    localparam logic [4:0] OP_BNE  = 5'd1;
    localparam logic [4:0] OP_BLT  = 5'd2;
    localparam logic [4:0] OP_BGE  = 5'd3;
    localparam logic [4:0] OP_BLTU = 5'd4;
    localparam logic [4:0] OP_BGEU = 5'd5;
    localparam logic [4:0] OP_ADD  = 5'd6;
    localparam logic [4:0] OP_SUB  = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8;
    localparam logic [4:0] OP_SLT  = 5'd9;
    localparam logic [4:0] OP_SLTU = 5'd10;
    localparam logic [4:0] OP_XOR  = 5'd11;
    localparam logic [4:0] OP_SRL  = 5'd12;
    localparam logic [4:0] OP_SRA  = 5'd13;
    localparam logic [4:0] OP_OR   = 5'd14;
    localparam logic [4:0] OP_AND  = 5'd15;
    localparam logic [4:0] OP_NOP  = 5'd16;

endpackage

// File: rtl/alu_adder32.sv
// 32-bit adder/subtractor with carry-out and signed overflow.
// With sub=1 it computes a + ~b + 1, so carry_out=1 means "no borrow" (a >= b unsigned).
module alu_adder32
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sub,
    output logic [XLEN-1:0] sum,
    output logic            carry_out,
    output logic            overflow
);

    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   full;

    // Operand inversion plus carry-in implements two's-complement subtraction
    always_comb begin
        b_eff     = sub ? ~b : b;
        full      = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
        sum       = full[XLEN-1:0];
        carry_out = full[XLEN];
        overflow  = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
    end

endmodule

// File: rtl/alu_arith_logic.sv
// Registered add/sub, compare and bitwise-logic slice of the ALU.
// Shift, NOP and unused op codes drive every result to zero.
module alu_arith_logic
    import alu_pkg::*;
(
    input  logic            soc_clk,
    input  logic            reset,
    input  logic            dat_ready,
    input  logic [XLEN-1:0] ALU_dat1,
    input  logic [XLEN-1:0] ALU_dat2,
    input  logic [4:0]      Instruction_to_ALU,
    output logic [XLEN-1:0] AddSub_out,
    output logic            AddSub_overflow,
    output logic            AddSub_zero,
    output logic [XLEN-1:0] Comparator_out,
    output logic            Comparator_con_met,
    output logic [XLEN-1:0] LogOp_out
);

    logic [XLEN-1:0] sum;
    logic            carry_out;
    logic            ovf;
    logic            sub;
    logic            lt_s;
    logic            lt_u;
    logic            eq;

    logic [XLEN-1:0] addsub_d;
    logic            ovf_d;
    logic            zero_d;
    logic            con_met_d;
    logic [XLEN-1:0] logop_d;

    // Adder subtracts for everything but ADD so compares share the subtract path
    assign sub = (Instruction_to_ALU != OP_ADD);

    alu_adder32 u_adder (
        .a         (ALU_dat1),
        .b         (ALU_dat2),
        .sub       (sub),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (ovf)
    );

    // Less-than from the subtract: signed via sign^overflow, unsigned via borrow
    always_comb begin
        lt_s = sum[XLEN-1] ^ ovf;
        lt_u = ~carry_out;
        eq   = (ALU_dat1 == ALU_dat2);
    end

    // Opcode decode into next-state values for the three result groups
    always_comb begin
        addsub_d  = '0;
        ovf_d     = 1'b0;
        zero_d    = 1'b0;
        con_met_d = 1'b0;
        logop_d   = '0;
        case (Instruction_to_ALU)
            OP_ADD, OP_SUB: begin
                addsub_d = sum;
                ovf_d    = ovf;
                zero_d   = (sum == '0);
            end
            OP_BEQ:           con_met_d = eq;
            OP_BNE:           con_met_d = ~eq;
            OP_BLT, OP_SLT:   con_met_d = lt_s;
            OP_BGE:           con_met_d = ~lt_s;
            OP_BLTU, OP_SLTU: con_met_d = lt_u;
            OP_BGEU:          con_met_d = ~lt_u;
            OP_XOR:           logop_d   = ALU_dat1 ^ ALU_dat2;
            OP_OR:            logop_d   = ALU_dat1 | ALU_dat2;
            OP_AND:           logop_d   = ALU_dat1 & ALU_dat2;
            default: ;
        endcase
    end

    // Result registers: reset clears, dat_ready loads, otherwise hold
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            AddSub_out         <= '0;
            AddSub_overflow    <= 1'b0;
            AddSub_zero        <= 1'b0;
            Comparator_con_met <= 1'b0;
            LogOp_out          <= '0;
        end else if (dat_ready) begin
            AddSub_out         <= addsub_d;
            AddSub_overflow    <= ovf_d;
            AddSub_zero        <= zero_d;
            Comparator_con_met <= con_met_d;
            LogOp_out          <= logop_d;
        end
    end

    // Comparison result travels on the flag; the word output is constant zero
    assign Comparator_out = '0;

endmodule

// File: tb/tb_alu_arith_logic.sv
// Directed bench for alu_arith_logic with hand-computed expected values.
module tb_alu_arith_logic;

    logic        soc_clk = 1'b0;
    logic        reset;
    logic        dat_ready;
    logic [31:0] ALU_dat1;
    logic [31:0] ALU_dat2;
    logic [4:0]  Instruction_to_ALU;
    logic [31:0] AddSub_out;
    logic        AddSub_overflow;
    logic        AddSub_zero;
    logic [31:0] Comparator_out;
    logic        Comparator_con_met;
    logic [31:0] LogOp_out;

    int compared   = 0;
    int mismatched = 0;

    alu_arith_logic dut (
        .soc_clk            (soc_clk),
        .reset              (reset),
        .dat_ready          (dat_ready),
        .ALU_dat1           (ALU_dat1),
        .ALU_dat2           (ALU_dat2),
        .Instruction_to_ALU (Instruction_to_ALU),
        .AddSub_out         (AddSub_out),
        .AddSub_overflow    (AddSub_overflow),
        .AddSub_zero        (AddSub_zero),
        .Comparator_out     (Comparator_out),
        .Comparator_con_met (Comparator_con_met),
        .LogOp_out          (LogOp_out)
    );

    always #5 soc_clk = ~soc_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs, then sample 1 time unit after the next rising edge
    task automatic step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        Instruction_to_ALU = op;
        ALU_dat1           = a;
        ALU_dat2           = b;
        @(posedge soc_clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] sum, input logic ovf,
                           input logic zero, input logic con, input logic [31:0] lg);
        chk({tag, ".sum"},  AddSub_out, sum);
        chk({tag, ".ovf"},  {31'd0, AddSub_overflow}, {31'd0, ovf});
        chk({tag, ".zero"}, {31'd0, AddSub_zero}, {31'd0, zero});
        chk({tag, ".cmp"},  Comparator_out, 32'h0);
        chk({tag, ".con"},  {31'd0, Comparator_con_met}, {31'd0, con});
        chk({tag, ".log"},  LogOp_out, lg);
    endtask

    initial begin
        reset     = 1'b1;
        dat_ready = 1'b1;
        step(5'd6, 32'd5, 32'd7);
        step(5'd6, 32'd5, 32'd7);
        chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        reset = 1'b0;
        step(5'd6, 32'd5, 32'd7);
        chk_all("add_5_7", 32'd12, 1'b0, 1'b0, 1'b0, 32'h0);

        step(5'd6, 32'h7FFF_FFFF, 32'd1);
        chk_all("add_ovf", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0);

        step(5'd7, 32'h1234, 32'h1234);
        chk_all("sub_zero", 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);

        step(5'd7, 32'h8000_0000, 32'd1);
        chk_all("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0);

        step(5'd7, 32'd3, 32'd5);
        chk_all("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 32'h0);

        step(5'd2, 32'hFFFF_FFFF, 32'd1);
        chk_all("blt", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        step(5'd4, 32'hFFFF_FFFF, 32'd1);
        chk_all("bltu", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(5'd5, 32'hFFFF_FFFF, 32'd1);
        chk_all("bgeu", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        step(5'd9, 32'hFFFF_FFFF, 32'd1);
        chk_all("slt", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        step(5'd10, 32'hFFFF_FFFF, 32'd1);
        chk_all("sltu", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(5'd3, 32'hFFFF_FFFF, 32'd1);
        chk_all("bge_neg", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        step(5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        chk_all("beq", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        step(5'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        chk_all("bne", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        chk_all("bge_eq", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        step(5'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEE);
        chk_all("bne_diff", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);

        step(5'd11, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk_all("xor", 32'h0, 1'b0, 1'b0, 1'b0, 32'hFF00_FF00);
        step(5'd14, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk_all("or", 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFF0_FFF0);
        step(5'd15, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk_all("and", 32'h0, 1'b0, 1'b0, 1'b0, 32'h00F0_00F0);

        // Hold: outputs must not follow new inputs while dat_ready is low
        dat_ready = 1'b0;
        step(5'd6, 32'd1, 32'd2);
        step(5'd0, 32'd9, 32'd9);
        chk_all("hold", 32'h0, 1'b0, 1'b0, 1'b0, 32'h00F0_00F0);

        dat_ready = 1'b1;
        step(5'd12, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk_all("srl_clear", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        step(5'd6, 32'd100, 32'd23);
        chk_all("add_again", 32'd123, 1'b0, 1'b0, 1'b0, 32'h0);
        step(5'd16, 32'd100, 32'd23);
        chk_all("nop_clear", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        step(5'd0, 32'd4, 32'd4);
        step(5'd31, 32'd4, 32'd4);
        chk_all("op31_clear", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset mid-operation beats dat_ready, then results resume after one edge
        step(5'd6, 32'd40, 32'd2);
        chk_all("pre_reset", 32'd42, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        step(5'd6, 32'd40, 32'd2);
        chk_all("mid_reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        step(5'd7, 32'd40, 32'd2);
        chk_all("post_reset", 32'd38, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_arith_logic.md
# alu_arith_logic

Registered integer execution slice of the ThetaCore ALU covering the add/subtract, compare/branch-condition and bitwise-logic datapaths. It receives two 32-bit operands and a decoded 5-bit ALU instruction code from the IDU→CU path. It presents three independent result groups (sum, compare flag, logic result) that the ALU top selects from when it raises `ALU_ready`. Shifts are handled by a separate shifter, not by this block.

## Interface
- No parameters; opcode values are package constants.
- `soc_clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high; one clock and reset, polarity/synchronicity fixed.
- `dat_ready` in 1: operands/opcode valid; results update only while high.
- `ALU_dat1` in 32: operand A (rs1).
- `ALU_dat2` in 32: operand B (rs2 or immediate).
- `Instruction_to_ALU` in 5: decoded op code.
- `AddSub_out` out 32: A+B or A−B.
- `AddSub_overflow` out 1: signed two's-complement overflow of add/sub.
- `AddSub_zero` out 1: add/sub result equals zero.
- `Comparator_out` out 32: always 32'h0; the comparison result is carried on the flag.
- `Comparator_con_met` out 1: branch condition / set-less-than result.
- `LogOp_out` out 32: bitwise result.

## Operation
- Op codes: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 ADD/ADDI, 7 SUB, 8 SLL, 9 SLT/SLTI, 10 SLTU, 11 XOR, 12 SRL, 13 SRA, 14 OR, 15 AND, 16 invalid/NOP.
- AddSub:
  - Op 6: out = A+B mod 2^32.
  - Op 7: out = A−B mod 2^32.
  - Overflow = (sign A == sign B') && (sign out != sign B'), where B' = B for op 6 and ~B+1 semantics for op 7. This is equivalent to the standard signed-overflow rule for subtraction.
  - Zero = (out == 0).
  - Any other op: out = 0, overflow = 0, zero = 0.
- Comparator:
  - con_met by op: 0 A==B; 1 A!=B; 2 and 9 signed A<B; 3 signed A>=B; 4 and 10 unsigned A<B; 5 unsigned A>=B.
  - Any other op: con_met = 0.
  - `Comparator_out` is always 0.
- LogOp:
  - Op 11: A^B. Op 14: A|B. Op 15: A&B.
  - Any other op: 0.
- Shift ops (8, 12, 13), op 16 and codes 17–31 drive every output of this block to 0. No error flag is raised here; the top owns `ALU_err`.

## Timing
- All outputs are registered.
- Rising `soc_clk` with `reset`=1: every output is cleared to 0. Reset has priority over `dat_ready`.
- Rising `soc_clk` with `reset`=0 and `dat_ready`=1: every output loads the function of the current inputs. Latency is 1 cycle.
- `dat_ready`=0: all outputs hold their last values.
- Back-to-back ops: each cycle with `dat_ready` high overwrites the results. Inputs are sampled every such cycle, so a change in operands or opcode mid-window is reflected on the next edge.
- The top samples results after 3 `dat_ready` cycles. This block must be stable from cycle 1 onward while inputs are constant.
- Reset asserted mid-operation clears outputs on that edge. The next valid result appears 1 cycle after `reset` deasserts with `dat_ready` high.

## Structure
- Shared package `alu_pkg` holds:
  - Op-code localparams `OP_BEQ`…`OP_NOP` (values above).
  - Width constant `XLEN = 32`.
- One natural sub-module, `alu_adder32`: 33-bit adder with carry-in for subtraction, producing sum, carry-out and signed overflow.
  - It serves ADD/SUB directly.
  - Its subtract path may be reused by the comparator for signed/unsigned less-than. Signed uses sign⊕overflow; unsigned uses the inverted borrow.
- Top level: opcode decode, three output register groups, synchronous reset.

## Test plan
- Reset: assert `reset` for 2 cycles with `dat_ready`=1 and op 6, A=5, B=7 → all outputs 0. Deassert → next edge `AddSub_out`=12, zero=0, overflow=0.
- Add/sub boundaries:
  - Op 6, A=32'h7FFFFFFF, B=1 → out 32'h80000000, overflow=1.
  - Op 7, A=B=32'h1234 → out 0, zero=1.
  - Op 7, A=32'h80000000, B=1 → out 32'h7FFFFFFF, overflow=1.
- Signed vs unsigned compare, A=32'hFFFFFFFF, B=1:
  - Op 2 → con_met=1. Op 4 → 0. Op 5 → 1. Op 9 → 1. Op 10 → 0.
  - `Comparator_out` = 0 throughout.
- Equality, A=B=32'hDEADBEEF: op 0 → con_met=1; op 1 → 0; op 3 → 1.
- Logic, A=32'hF0F0F0F0, B=32'h0FF00FF0:
  - Op 11 → 32'hFF00FF00. Op 14 → 32'hFFF0FFF0. Op 15 → 32'h00F000F0.
- Hold and clear:
  - Drop `dat_ready` after op 15, then change the inputs → outputs unchanged.
  - Raise `dat_ready` with op 12 or op 16 → all outputs 0.
